// File: rtl/line_engine_if.sv
// Command and pixel handshake bundle for line_engine.
// The controller side uses the master modport; the engine uses the slave modport.
interface line_engine_if #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int COLOR_W = 1
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [XW-1:0]      x0;
    logic [XW-1:0]      x1;
    logic [YW-1:0]      y0;
    logic [YW-1:0]      y1;
    logic [COLOR_W-1:0] color;
    logic               pix_valid;
    logic               pix_ready;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               busy;
    logic               done;

    modport master (
        output cmd_valid, x0, x1, y0, y1, color, pix_ready,
        input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
    );

    modport slave (
        input  cmd_valid, x0, x1, y0, y1, color, pix_ready,
        output cmd_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
    );
endinterface

// File: rtl/line_engine.sv
// Bresenham line rasteriser, all eight octants, one pixel per handshake with backpressure.
// Optional screen clipping is compiled in with `define LINE_ENGINE_CLIP_EN.
module line_engine #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int COLOR_W = 1,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic         clk,
    input  logic         reset_n,
    line_engine_if.slave bus
);
    localparam int MW = (XW > YW) ? XW : YW;
    localparam int W  = MW + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [XW-1:0]       x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
    logic [YW-1:0]       y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic [XW-1:0]       abs_dx;
    logic [YW-1:0]       abs_dy;
    logic signed [W-1:0] e2, err_n;
    logic                at_end, on_screen, advance;

    assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

`ifdef LINE_ENGINE_CLIP_EN
    localparam logic [XW:0] H_LIM = (XW+1)'(H_RES);
    localparam logic [YW:0] V_LIM = (YW+1)'(V_RES);
    assign on_screen = ({1'b0, cur_x_q} < H_LIM) && ({1'b0, cur_y_q} < V_LIM);
    // Off-screen pixels are never offered, so they retire without waiting for pix_ready.
    assign advance   = on_screen ? bus.pix_ready : 1'b1;
`else
    logic unused_clip_cfg;
    assign unused_clip_cfg = ^{H_RES, V_RES};
    assign on_screen       = 1'b1;
    assign advance         = bus.pix_ready;
`endif

    // NOTE: combinational next-state logic uses blocking '=' with a default for every
    // variable first, so no latches are inferred; flops below use only '<='.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        color_d  = color_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        abs_dx   = '0;
        abs_dy   = '0;
        e2       = '0;
        err_n    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    x0_d    = bus.x0;
                    x1_d    = bus.x1;
                    y0_d    = bus.y0;
                    y1_d    = bus.y1;
                    color_d = bus.color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                sx_neg_d = (x1_q < x0_q);
                sy_neg_d = (y1_q < y0_q);
                abs_dx   = sx_neg_d ? (x0_q - x1_q) : (x1_q - x0_q);
                abs_dy   = sy_neg_d ? (y0_q - y1_q) : (y1_q - y0_q);
                dx_d     = signed'({{(W-XW){1'b0}}, abs_dx});
                dy_d     = signed'({{(W-YW){1'b0}}, abs_dy});
                err_d    = dx_d - dy_d;
                cur_x_d  = x0_q;
                cur_y_d  = y0_q;
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        // Both tests use the pre-step error so diagonal moves stay exact.
                        e2 = err_q <<< 1;
                        if (e2 >= -dy_q) begin
                            err_n   = err_n - dy_q;
                            cur_x_d = sx_neg_q ? (cur_x_q - XW'(1)) : (cur_x_q + XW'(1));
                        end
                        if (e2 <= dx_q) begin
                            err_n   = err_n + dx_q;
                            cur_y_d = sy_neg_q ? (cur_y_q - YW'(1)) : (cur_y_q + YW'(1));
                        end
                        err_d = err_n;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_SETUP) || (state_q == S_DRAW);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pix_valid = (state_q == S_DRAW) && on_screen;
    assign bus.pix_x     = cur_x_q;
    assign bus.pix_y     = cur_y_q;
    assign bus.pix_color = color_q;
endmodule

// File: tb/tb_line_engine.sv
// Self-checking bench for line_engine: table of line commands with a pixel scoreboard,
// plus hand-written backpressure, reset-abort and degenerate-line sequences.
module tb_line_engine;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int CW    = 1;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

`ifdef LINE_ENGINE_CLIP_EN
    localparam int CLIP_N  = 10;
    localparam int CLIP_LX = 639;
`else
    localparam int CLIP_N  = 21;
    localparam int CLIP_LX = 650;
`endif

    typedef struct {
        int x0; int y0; int x1; int y1; int col;
        int n;  int lx; int ly; int stall_at; int stall_len;
    } vec_t;

    typedef struct { int x; int y; int c; } pix_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    pix_t exp_q[$];

    line_engine_if #(.XW(XW), .YW(YW), .COLOR_W(CW)) bus ();

    line_engine #(
        .XW(XW), .YW(YW), .COLOR_W(CW), .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit visible(input int x, input int y);
`ifdef LINE_ENGINE_CLIP_EN
        return (x < H_RES) && (y < V_RES);
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    // Reference Bresenham walk; pushes every presented pixel to the scoreboard.
    task automatic model(input int x0, input int y0, input int x1, input int y1, input int c);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 >= y0) ? y1 - y0 : y0 - y1;
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        err = dx - dy;
        x   = x0;
        y   = y0;
        for (int i = 0; i < 4096; i++) begin
            if (visible(x, y)) exp_q.push_back('{x, y, c});
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= -dy) begin err -= dy; x += sx; end
            if (e2 <= dx)  begin err += dx; y += sy; end
        end
    endtask

    task automatic run_line(input vec_t v, input int abort_at,
                            output int n_pix, output int lx, output int ly);
        int   cyc, last_cyc, stalls, held_x, held_y;
        bit   done_seen, end_vis, first_vis;
        pix_t p;
        n_pix = 0; lx = -1; ly = -1; stalls = 0; held_x = 0; held_y = 0;
        done_seen = 1'b0; last_cyc = -10;
        exp_q.delete();

        bus.x0        = XW'(v.x0);
        bus.y0        = YW'(v.y0);
        bus.x1        = XW'(v.x1);
        bus.y1        = YW'(v.y1);
        bus.color     = CW'(v.col);
        bus.cmd_valid = 1'b1;
        bus.pix_ready = 1'b1;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);

        model(v.x0, v.y0, v.x1, v.y1, v.col);
        end_vis   = visible(v.x1, v.y1);
        first_vis = visible(v.x0, v.y0);
        step();
        bus.cmd_valid = 1'b0;
        check("setup_busy", bus.busy, 1);
        check("setup_no_pix", bus.pix_valid, 0);
        check("setup_cmd_ready", bus.cmd_ready, 0);
        step();
        check("first_pix_latency", bus.pix_valid, first_vis);

        for (cyc = 2; cyc < 3000; cyc++) begin
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (abort_at >= 0 && n_pix == abort_at && bus.pix_valid === 1'b1) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
                check("abort_pix_valid", bus.pix_valid, 0);
                check("abort_cmd_ready", bus.cmd_ready, 1);
                check("abort_busy", bus.busy, 0);
                check("abort_done", bus.done, 0);
                for (int k = 0; k < 4; k++) begin
                    step();
                    check("abort_no_done", bus.done, 0);
                end
                exp_q.delete();
                return;
            end
            bus.pix_ready = 1'b1;
            if (v.stall_at >= 0 && n_pix == v.stall_at && stalls < v.stall_len
                && bus.pix_valid === 1'b1) begin
                if (stalls == 0) begin
                    held_x = int'(bus.pix_x);
                    held_y = int'(bus.pix_y);
                end else begin
                    check("stall_x", bus.pix_x, held_x);
                    check("stall_y", bus.pix_y, held_y);
                    check("stall_valid", bus.pix_valid, 1);
                end
                bus.pix_ready = 1'b0;
                stalls++;
            end else if (stalls > 0 && n_pix == v.stall_at) begin
                check("stall_release_x", bus.pix_x, held_x);
                check("stall_release_y", bus.pix_y, held_y);
            end
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
                check("pix_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    check("pix_x", bus.pix_x, p.x);
                    check("pix_y", bus.pix_y, p.y);
                    check("pix_color", bus.pix_color, p.c);
                end
                n_pix++;
                lx = int'(bus.pix_x);
                ly = int'(bus.pix_y);
                last_cyc = cyc;
            end
            step();
        end
        bus.pix_ready = 1'b1;

        check("done_seen", done_seen, 1);
        if (done_seen) begin
            if (end_vis) check("done_latency", cyc, last_cyc + 1);
            check("done_pix_valid", bus.pix_valid, 0);
            check("done_busy", bus.busy, 0);
            check("done_cmd_ready", bus.cmd_ready, 0);
            step();
            check("idle_cmd_ready", bus.cmd_ready, 1);
            check("idle_done_low", bus.done, 0);
        end
        check("all_pixels_drawn", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t av;
        int   n, lx, ly;

        vecs[0] = '{100, 100, 240, 240, 1, 141, 240, 240, -1, 0};
        vecs[1] = '{  5,   5,   5,   5, 1,   1,   5,   5, -1, 0};
        vecs[2] = '{ 10,  50,  12,  40, 1,  11,  12,  40, -1, 0};
        vecs[3] = '{  0,   0,   7,   3, 1,   8,   7,   3,  2, 3};
        vecs[4] = '{  3, 200,   0,   0, 0, 201,   0,   0, -1, 0};
        vecs[5] = '{ 50,  10,  20,  30, 1,  31,  20,  30, -1, 0};
        vecs[6] = '{630, 470, 650, 470, 1, CLIP_N, CLIP_LX, 470, -1, 0};
        vecs[7] = '{  0,   0, 300,  10, 1, 301, 300,  10,  5, 2};
        av      = '{  0,   0, 300,  10, 1,   0,   0,   0, -1, 0};

        bus.cmd_valid = 1'b0;
        bus.pix_ready = 1'b1;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0; bus.color = '0;

        reset_n = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pix_x", bus.pix_x, 0);
        check("rst_pix_y", bus.pix_y, 0);
        check("rst_pix_color", bus.pix_color, 0);
        reset_n = 1'b1;
        step();

        run_line(av, 19, n, lx, ly);
        check("abort_count", n, 19);

        for (int i = 0; i < 8; i++) begin
            run_line(vecs[i], -1, n, lx, ly);
            check($sformatf("v%0d_count", i), n, vecs[i].n);
            check($sformatf("v%0d_last_x", i), lx, vecs[i].lx);
            check($sformatf("v%0d_last_y", i), ly, vecs[i].ly);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
